traffic_light_monitor: RTL
==========================

Name: traffic_light_monitor

Overview:
- Checker at the consuming end of the traffic-light lamp interface.
- Observes light_green/light_yellow/light_red plus the two NMI inputs, once per pulse_1s.
- Verifies lamp exclusivity, phase order GREEN->YELLOW->RED->GREEN, and per-phase dwell times; reports sticky fault flags and a saturating fault count.
- Sits beside the controller in the intersection top level; its outputs feed the status register and the fault LED.

Parameters:
- GREEN_PULSES, 11, exact green dwell in pulse_1s samples with no emergency.
- YELLOW_PULSES, 6, exact yellow dwell in samples.
- RED_PULSES, 16, minimum red dwell (red and dark samples combined).
- CNT_W, 8, width of the dwell counter and fault counter; both saturate at 2^CNT_W-1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pulse_1s  in  1  one-clk sample strobe
- light_green  in  1  observed green lamp
- light_yellow  in  1  observed yellow lamp
- light_red  in  1  observed red lamp
- nmi_emergency_vehicle  in  1  emergency request (excuses short green, long red)
- nmi_power_outage  in  1  outage (excuses dark samples in red, long red)
- err_clr  in  1  one-clk clear of sticky flags and fault count
- mon_phase  out  2  0=IDLE 1=GREEN 2=YELLOW 3=RED
- err_multi_lamp  out  1  sticky: more than one lamp lit
- err_sequence  out  1  sticky: illegal phase transition or illegal dark
- err_dwell  out  1  sticky: dwell out of range
- err_any  out  1  OR of the three sticky flags, registered
- err_count  out  CNT_W  number of samples flagging at least one error, saturating

Behaviour:
- Reset: clk is the only clock; reset is synchronous and active-high.
  - All outputs reset to 0; mon_phase=IDLE.
  - dwell=0; first_phase=1; emg_seen=0; outage_d=0.
- Evaluation: all evaluation happens only on clk cycles with pulse_1s=1. Outputs update one clk after the sample.
- Lamp decode {g,y,r}:
  - 000 = DARK; 100 = GREEN; 010 = YELLOW; 001 = RED.
  - Any other value = MULTI.
- MULTI in any state: set err_multi_lamp; mon_phase<=IDLE; first_phase<=1.
- IDLE:
  - DARK: ignored.
  - Any single lamp: enter that phase with dwell=1, first_phase=1, no checks.
- GREEN:
  - GREEN: dwell++. If dwell becomes >GREEN_PULSES, set err_dwell once at the crossing.
  - YELLOW: check the green dwell, then enter YELLOW with dwell=1.
    - Without emg_seen, dwell must equal GREEN_PULSES.
    - With emg_seen, dwell must be in 1..GREEN_PULSES.
    - Check is skipped if first_phase=1.
  - RED or DARK: set err_sequence; resync to the RED phase (DARK also resyncs to RED) with first_phase=1.
- YELLOW:
  - YELLOW: dwell++. Set err_dwell when dwell exceeds YELLOW_PULSES.
  - RED: check dwell==YELLOW_PULSES unless first_phase=1, then enter RED.
  - GREEN or DARK: set err_sequence and resync as above.
- RED:
  - RED: dwell++.
  - DARK: dwell++. Legal only if nmi_power_outage=1 or outage_d=1; otherwise set err_sequence.
  - GREEN: set err_dwell if dwell<RED_PULSES and first_phase=0, then enter GREEN with dwell=1.
  - YELLOW: set err_sequence and resync.
  - No red maximum is checked.
- Phase entry: first_phase<=0 on every legal transition. emg_seen is cleared on entry to GREEN and set by nmi_emergency_vehicle sampled during GREEN. outage_d<=nmi_power_outage on every sample.
- err_count: increments by 1 per sample in which any error is detected, not per flag.
- err_clr vs. a new error in the same cycle: the new error wins. Flags are set and err_count becomes 1.
- Reset mid-phase: full return to IDLE. The controller's post-reset dark sample is ignored in IDLE.

Decomposition:
- Package traffic_pkg holds:
  - phase encodings (PH_IDLE/GREEN/YELLOW/RED);
  - lamp code constants;
  - default durations shared with the controller (10/5/15 timer loads, giving 11/6/16 samples).
- One natural sub-module: sat_counter (CNT_W, clear, load-1, increment, saturate), instantiated for dwell and for err_count.

Test Plan:
- Nominal: 1 dark, then green 11, yellow 6, red 16, green -> no flags; mon_phase sequence 0,1,2,3,1; err_count=0.
- Emergency: green 4 samples with nmi_emergency_vehicle=1, then yellow 6 -> no flags. The same without the NMI -> err_dwell=1, err_count=1.
- Multi-lamp: sample {g,y,r}=110 mid-green -> err_multi_lamp=1, mon_phase=0. Next green sample enters GREEN with no further flags.
- Flash: in red with outage=1, alternate red/dark for 20 samples -> no flags. A dark sample after outage has been low for 2 samples -> err_sequence=1.
- Sequence/dwell: green->red -> err_sequence. Yellow held 7 samples -> err_dwell at sample 7. Red 10 then green -> err_dwell. err_count=3.
- Clear and saturation: 300 erroring samples with CNT_W=8 -> err_count=255. err_clr in the same cycle as an error -> err_count=1, flag remains set.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic-light controller and its lamp monitor:
// phase codes, lamp codes and the default timer loads.
package traffic_pkg;

  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_GREEN  = 2'd1,
    PH_YELLOW = 2'd2,
    PH_RED    = 2'd3
  } phase_t;

  // Lamp codes as {green, yellow, red}
  localparam logic [2:0] LAMP_DARK   = 3'b000;
  localparam logic [2:0] LAMP_GREEN  = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_RED    = 3'b001;

  // Controller timer loads; a load of N yields N+1 pulse_1s samples
  localparam int GREEN_LOAD  = 10;
  localparam int YELLOW_LOAD = 5;
  localparam int RED_LOAD    = 15;

  function automatic logic lamp_is_legal(input logic [2:0] lamp);
    case (lamp)
      LAMP_DARK, LAMP_GREEN, LAMP_YELLOW, LAMP_RED: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Dark maps to RED: a dark lamp is only ever legal as part of a red flash
  function automatic phase_t lamp_phase(input logic [2:0] lamp);
    case (lamp)
      LAMP_GREEN:  return PH_GREEN;
      LAMP_YELLOW: return PH_YELLOW;
      default:     return PH_RED;
    endcase
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with clear and load-to-one; load wins over clear so a
// same-cycle event survives a clear request.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         load_one,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX_VAL = {W{1'b1}};
  localparam logic [W-1:0] ONE_VAL = {{(W-1){1'b0}}, 1'b1};

  // Counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= {W{1'b0}};
    end else if (load_one) begin
      count <= ONE_VAL;
    end else if (clr) begin
      count <= {W{1'b0}};
    end else if (inc && (count != MAX_VAL)) begin
      count <= count + ONE_VAL;
    end
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Lamp-interface checker: once per pulse_1s it tracks the observed phase and
// flags multi-lamp, out-of-order and wrong-dwell behaviour.
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int GREEN_PULSES  = GREEN_LOAD + 1,
  parameter int YELLOW_PULSES = YELLOW_LOAD + 1,
  parameter int RED_PULSES    = RED_LOAD + 1,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pulse_1s,
  input  logic             light_green,
  input  logic             light_yellow,
  input  logic             light_red,
  input  logic             nmi_emergency_vehicle,
  input  logic             nmi_power_outage,
  input  logic             err_clr,
  output logic [1:0]       mon_phase,
  output logic             err_multi_lamp,
  output logic             err_sequence,
  output logic             err_dwell,
  output logic             err_any,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [CNT_W-1:0] G_LIM = CNT_W'(GREEN_PULSES);
  localparam logic [CNT_W-1:0] Y_LIM = CNT_W'(YELLOW_PULSES);
  localparam logic [CNT_W-1:0] R_LIM = CNT_W'(RED_PULSES);

  logic [2:0]       lamp_s;
  phase_t           lamp_ph_s;
  phase_t           phase_r;
  phase_t           phase_nxt_s;
  logic             first_phase_r;
  logic             first_nxt_s;
  logic             emg_seen_r;
  logic             emg_nxt_s;
  logic             outage_d_r;
  logic [CNT_W-1:0] dwell_r;
  logic             dwell_clr_s;
  logic             dwell_load_s;
  logic             dwell_inc_s;
  logic             det_multi_s;
  logic             det_seq_s;
  logic             det_dwell_s;
  logic             det_any_s;
  logic             multi_nxt_s;
  logic             seq_nxt_s;
  logic             dwell_err_nxt_s;

  assign lamp_s    = {light_green, light_yellow, light_red};
  assign lamp_ph_s = lamp_phase(lamp_s);
  assign mon_phase = phase_r;

  // Phase tracking, dwell control and per-sample error detection
  always_comb begin
    phase_nxt_s  = phase_r;
    first_nxt_s  = first_phase_r;
    det_multi_s  = 1'b0;
    det_seq_s    = 1'b0;
    det_dwell_s  = 1'b0;
    dwell_clr_s  = 1'b0;
    dwell_load_s = 1'b0;
    dwell_inc_s  = 1'b0;
    if (!pulse_1s) begin
      phase_nxt_s = phase_r;
    end else if (!lamp_is_legal(lamp_s)) begin
      det_multi_s = 1'b1;
      phase_nxt_s = PH_IDLE;
      first_nxt_s = 1'b1;
      dwell_clr_s = 1'b1;
    end else begin
      case (phase_r)
        PH_IDLE: begin
          if (lamp_s != LAMP_DARK) begin
            phase_nxt_s  = lamp_ph_s;
            first_nxt_s  = 1'b1;
            dwell_load_s = 1'b1;
          end else begin
            phase_nxt_s = PH_IDLE;
          end
        end
        PH_GREEN: begin
          case (lamp_s)
            LAMP_GREEN: begin
              dwell_inc_s = 1'b1;
              det_dwell_s = (dwell_r == G_LIM);
            end
            LAMP_YELLOW: begin
              // An emergency excuses a short green, never a long one
              det_dwell_s  = !first_phase_r &&
                             (emg_seen_r ? (dwell_r > G_LIM) : (dwell_r != G_LIM));
              phase_nxt_s  = PH_YELLOW;
              first_nxt_s  = 1'b0;
              dwell_load_s = 1'b1;
            end
            default: begin
              det_seq_s    = 1'b1;
              phase_nxt_s  = lamp_ph_s;
              first_nxt_s  = 1'b1;
              dwell_load_s = 1'b1;
            end
          endcase
        end
        PH_YELLOW: begin
          case (lamp_s)
            LAMP_YELLOW: begin
              dwell_inc_s = 1'b1;
              det_dwell_s = (dwell_r == Y_LIM);
            end
            LAMP_RED: begin
              det_dwell_s  = !first_phase_r && (dwell_r != Y_LIM);
              phase_nxt_s  = PH_RED;
              first_nxt_s  = 1'b0;
              dwell_load_s = 1'b1;
            end
            default: begin
              det_seq_s    = 1'b1;
              phase_nxt_s  = lamp_ph_s;
              first_nxt_s  = 1'b1;
              dwell_load_s = 1'b1;
            end
          endcase
        end
        PH_RED: begin
          case (lamp_s)
            LAMP_RED: begin
              dwell_inc_s = 1'b1;
            end
            LAMP_DARK: begin
              dwell_inc_s = 1'b1;
              det_seq_s   = !(nmi_power_outage || outage_d_r);
            end
            LAMP_GREEN: begin
              det_dwell_s  = !first_phase_r && (dwell_r < R_LIM);
              phase_nxt_s  = PH_GREEN;
              first_nxt_s  = 1'b0;
              dwell_load_s = 1'b1;
            end
            default: begin
              det_seq_s    = 1'b1;
              phase_nxt_s  = lamp_ph_s;
              first_nxt_s  = 1'b1;
              dwell_load_s = 1'b1;
            end
          endcase
        end
        default: begin
          phase_nxt_s = PH_IDLE;
          first_nxt_s = 1'b1;
        end
      endcase
    end
  end

  // emg_seen restarts on green entry and accumulates while green is held
  assign emg_nxt_s = (pulse_1s && (phase_nxt_s == PH_GREEN)) ?
                     (((phase_r == PH_GREEN) ? emg_seen_r : 1'b0) | nmi_emergency_vehicle) :
                     emg_seen_r;

  assign det_any_s       = det_multi_s | det_seq_s | det_dwell_s;
  assign multi_nxt_s     = det_multi_s | (err_multi_lamp & ~err_clr);
  assign seq_nxt_s       = det_seq_s   | (err_sequence   & ~err_clr);
  assign dwell_err_nxt_s = det_dwell_s | (err_dwell      & ~err_clr);

  // Phase-tracking state
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_r       <= PH_IDLE;
      first_phase_r <= 1'b1;
      emg_seen_r    <= 1'b0;
      outage_d_r    <= 1'b0;
    end else begin
      phase_r       <= phase_nxt_s;
      first_phase_r <= first_nxt_s;
      emg_seen_r    <= emg_nxt_s;
      outage_d_r    <= pulse_1s ? nmi_power_outage : outage_d_r;
    end
  end

  // Sticky fault flags
  always_ff @(posedge clk) begin
    if (reset) begin
      err_multi_lamp <= 1'b0;
      err_sequence   <= 1'b0;
      err_dwell      <= 1'b0;
      err_any        <= 1'b0;
    end else begin
      err_multi_lamp <= multi_nxt_s;
      err_sequence   <= seq_nxt_s;
      err_dwell      <= dwell_err_nxt_s;
      err_any        <= multi_nxt_s | seq_nxt_s | dwell_err_nxt_s;
    end
  end

  sat_counter #(.W(CNT_W)) u_dwell_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr      (dwell_clr_s),
    .load_one (dwell_load_s),
    .inc      (dwell_inc_s),
    .count    (dwell_r)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr      (err_clr),
    .load_one (err_clr & det_any_s),
    .inc      (det_any_s),
    .count    (err_count)
  );

endmodule
